// File: rtl/tone_phase_accumulator.sv
// Per-voice phase accumulator: advances a phase word by a gliding frequency word on
// each sample tick, with hard sync, gate and a one-cycle natural-wrap pulse.
module tone_phase_accumulator #(
    parameter int ACCUMULATOR_BITS = 24,
    parameter int FREQ_BITS        = 16
) (
    input  logic                        main_clk,
    input  logic                        rst_n,
    input  logic                        sample_clk,
    input  logic [FREQ_BITS-1:0]        tone_freq,
    input  logic                        freq_load,
    input  logic [3:0]                  glide_rate,
    input  logic                        enable,
    input  logic                        sync_in,
    output logic [ACCUMULATOR_BITS-1:0] accumulator,
    output logic                        wrap,
    output logic                        glide_active
);

    logic [ACCUMULATOR_BITS-1:0] r_accum;
    logic [FREQ_BITS-1:0]        r_target;
    logic [FREQ_BITS-1:0]        r_cur_freq;
    logic                        r_sync_prev;
    logic                        r_sync_pend;
    logic                        r_wrap;

    logic                        w_sync_edge;
    logic [ACCUMULATOR_BITS:0]   w_freq_ext;
    logic [ACCUMULATOR_BITS:0]   w_sum;

    // Step of |diff| >> rate never exceeds |diff|, and the +/-1 floor ends the
    // approach exactly on target, so the result cannot overshoot or leave range.
    function automatic logic [FREQ_BITS-1:0] glide_next(
        input logic [FREQ_BITS-1:0] cur,
        input logic [FREQ_BITS-1:0] tgt,
        input logic [3:0]           rate
    );
        logic signed [FREQ_BITS:0] diff;
        logic signed [FREQ_BITS:0] step;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        step = diff >>> rate;
        if (step == '0 && diff != '0) begin
            if (diff[FREQ_BITS]) step = '1;
            else                 step = {{FREQ_BITS{1'b0}}, 1'b1};
        end
        if (rate == 4'd0) glide_next = tgt;
        else              glide_next = cur + step[FREQ_BITS-1:0];
    endfunction

    assign w_sync_edge = sync_in & ~r_sync_prev;
    assign w_freq_ext  = (ACCUMULATOR_BITS + 1)'(r_cur_freq);
    assign w_sum       = {1'b0, r_accum} + w_freq_ext;

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accum     <= '0;
            r_target    <= '0;
            r_cur_freq  <= '0;
            r_sync_prev <= 1'b0;
            r_sync_pend <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_sync_prev <= sync_in;
            if (freq_load) r_target <= tone_freq;
            if (sample_clk) begin
                r_cur_freq  <= glide_next(r_cur_freq, r_target, glide_rate);
                r_sync_pend <= 1'b0;
                if (w_sync_edge || r_sync_pend) begin
                    r_accum <= '0;
                    r_wrap  <= 1'b0;
                end else if (enable) begin
                    r_accum <= w_sum[ACCUMULATOR_BITS-1:0];
                    r_wrap  <= w_sum[ACCUMULATOR_BITS];
                end else begin
                    r_wrap  <= 1'b0;
                end
            end else begin
                r_wrap <= 1'b0;
                if (w_sync_edge) r_sync_pend <= 1'b1;
            end
        end
    end

    assign accumulator  = r_accum;
    assign wrap         = r_wrap;
    assign glide_active = (r_cur_freq != r_target);

endmodule

// File: tb/tb_tone_phase_accumulator.sv
// Directed bench for tone_phase_accumulator: vector table for glide/gate/sync/load
// interactions plus hand-written wrap and asynchronous-reset sequences.
module tb_tone_phase_accumulator;

    logic        main_clk = 1'b0;
    logic        rst_n;
    logic        sample_clk;
    logic [15:0] tone_freq;
    logic        freq_load;
    logic [3:0]  glide_rate;
    logic        enable;
    logic        sync_in;
    logic [23:0] accumulator;
    logic        wrap;
    logic        glide_active;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        tick;
        logic        load;
        logic [15:0] freq;
        logic [3:0]  rate;
        logic        en;
        logic        sync;
        logic [23:0] acc;
        logic        wrp;
        logic        ga;
    } vec_t;

    vec_t vt[$];

    tone_phase_accumulator #(.ACCUMULATOR_BITS(24), .FREQ_BITS(16)) dut (
        .main_clk    (main_clk),
        .rst_n       (rst_n),
        .sample_clk  (sample_clk),
        .tone_freq   (tone_freq),
        .freq_load   (freq_load),
        .glide_rate  (glide_rate),
        .enable      (enable),
        .sync_in     (sync_in),
        .accumulator (accumulator),
        .wrap        (wrap),
        .glide_active(glide_active)
    );

    always #5 main_clk = ~main_clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push(input logic tk, input logic ld, input logic [15:0] fr, input logic [3:0] rt,
                        input logic en, input logic sy, input logic [23:0] acc, input logic wr,
                        input logic ga);
        vec_t v;
        v.tick = tk; v.load = ld; v.freq = fr; v.rate = rt; v.en = en; v.sync = sy;
        v.acc = acc; v.wrp = wr; v.ga = ga;
        vt.push_back(v);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
    task automatic drive(input logic tk, input logic ld, input logic [15:0] fr, input logic [3:0] rt,
                         input logic en, input logic sy);
        sample_clk = tk; freq_load = ld; tone_freq = fr; glide_rate = rt; enable = en; sync_in = sy;
        @(posedge main_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_clk = 0; freq_load = 0; tone_freq = '0; glide_rate = '0; enable = 0; sync_in = 0;
        repeat (2) @(posedge main_clk);
        #1;
        rst_n = 1'b1;
        chk("reset_acc", 32'(accumulator), 32'h0);
        chk("reset_wrap", 32'(wrap), 32'h0);
        chk("reset_glide_active", 32'(glide_active), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        sample_clk = 0; freq_load = 0; tone_freq = '0; glide_rate = '0; enable = 0; sync_in = 0;

        // Basic rate: 0x1000 per tick, wrap on tick 4097
        do_reset();
        drive(0, 1, 16'h1000, 4'd0, 1, 0);
        for (int k = 1; k <= 4097; k++) begin
            drive(1, 0, 16'h0, 4'd0, 1, 0);
            chk($sformatf("rate_acc_t%0d", k), 32'(accumulator), 32'((k - 1) * 32'h1000) & 32'hFFFFFF);
            chk($sformatf("rate_wrap_t%0d", k), 32'(wrap), (k == 4097) ? 32'h1 : 32'h0);
        end
        drive(0, 0, 16'h0, 4'd0, 1, 0);
        chk("wrap_one_cycle", 32'(wrap), 32'h0);
        chk("wrap_hold_acc", 32'(accumulator), 32'h0);
        drive(1, 0, 16'h0, 4'd0, 1, 0);
        chk("after_wrap_acc", 32'(accumulator), 32'h1000);

        // Vector table: glide, gate, load-on-tick, sync
        do_reset();
        push(0, 1, 16'h0100, 4'd2, 1, 0, 24'h000000, 0, 1);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h000000, 0, 1);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h000040, 0, 1);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h0000B0, 0, 1);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h000144, 0, 1);
        for (int i = 0; i < 10; i++) push(1, 0, 16'h0000, 4'd2, 0, 0, 24'h000144, 0, 1);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h00023E, 0, 1);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h000339, 0, 1);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h000435, 0, 1);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h000532, 0, 1);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h000630, 0, 1);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h00072F, 0, 0);
        push(1, 0, 16'h0000, 4'd2, 1, 0, 24'h00082F, 0, 0);
        push(0, 0, 16'h0000, 4'd2, 1, 0, 24'h00082F, 0, 0);
        push(0, 1, 16'h0200, 4'd0, 1, 0, 24'h00082F, 0, 1);
        push(1, 1, 16'h0300, 4'd0, 1, 0, 24'h00092F, 0, 1);
        push(1, 0, 16'h0000, 4'd0, 1, 0, 24'h000B2F, 0, 0);
        push(1, 0, 16'h0000, 4'd0, 1, 0, 24'h000E2F, 0, 0);
        push(0, 0, 16'h0000, 4'd0, 1, 1, 24'h000E2F, 0, 0);
        push(0, 0, 16'h0000, 4'd0, 1, 1, 24'h000E2F, 0, 0);
        push(1, 0, 16'h0000, 4'd0, 1, 1, 24'h000000, 0, 0);
        push(1, 0, 16'h0000, 4'd0, 1, 1, 24'h000300, 0, 0);
        push(1, 0, 16'h0000, 4'd0, 1, 0, 24'h000600, 0, 0);
        push(1, 0, 16'h0000, 4'd0, 1, 1, 24'h000000, 0, 0);
        push(1, 0, 16'h0000, 4'd0, 1, 1, 24'h000300, 0, 0);
        push(1, 0, 16'h0000, 4'd0, 0, 0, 24'h000300, 0, 0);
        push(1, 0, 16'h0000, 4'd0, 0, 1, 24'h000000, 0, 0);
        push(1, 0, 16'h0000, 4'd0, 1, 0, 24'h000300, 0, 0);
        foreach (vt[i]) begin
            drive(vt[i].tick, vt[i].load, vt[i].freq, vt[i].rate, vt[i].en, vt[i].sync);
            chk($sformatf("vec%0d_acc", i), 32'(accumulator), 32'(vt[i].acc));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vt[i].wrp));
            chk($sformatf("vec%0d_glide_active", i), 32'(glide_active), 32'(vt[i].ga));
        end

        // Async reset mid-glide with a sync pending
        drive(0, 1, 16'h1000, 4'd3, 1, 0);
        drive(1, 0, 16'h0000, 4'd3, 1, 0);
        drive(0, 0, 16'h0000, 4'd3, 1, 1);
        chk("pre_reset_acc", 32'(accumulator), 32'h600);
        chk("pre_reset_glide_active", 32'(glide_active), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_acc", 32'(accumulator), 32'h0);
        chk("async_reset_wrap", 32'(wrap), 32'h0);
        chk("async_reset_glide_active", 32'(glide_active), 32'h0);
        sync_in = 1'b0;
        @(negedge main_clk);
        rst_n = 1'b1;
        @(posedge main_clk);
        #1;
        drive(0, 1, 16'h0040, 4'd0, 1, 0);
        chk("post_reset_ga", 32'(glide_active), 32'h1);
        drive(1, 0, 16'h0000, 4'd0, 1, 0);
        chk("post_reset_tick1", 32'(accumulator), 32'h0);
        drive(1, 0, 16'h0000, 4'd0, 1, 0);
        chk("post_reset_tick2", 32'(accumulator), 32'h40);
        drive(1, 0, 16'h0000, 4'd0, 1, 0);
        chk("post_reset_tick3", 32'(accumulator), 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
